// File: rtl/tg_obuf_pkg.sv
// Shared flit layout and helpers for the traffic-generator output buffer.
package tg_obuf_pkg;

   localparam int TS_WIDTH      = 8;
   localparam int ADDR_WIDTH    = 4;
   localparam int FLIT_WIDTH    = 3 + TS_WIDTH + 2 * ADDR_WIDTH + 5;
   localparam int FLIT_HEAD_BIT = FLIT_WIDTH - 1;
   localparam int FLIT_TAIL_BIT = FLIT_WIDTH - 2;

   typedef struct packed {
      logic                  head;
      logic                  tail;
      logic                  measure;
      logic [TS_WIDTH-1:0]   ts;
      logic [ADDR_WIDTH-1:0] dest;
      logic [ADDR_WIDTH-1:0] src;
      logic [4:0]            pad;
   } flit_t;

   function automatic logic is_head(input logic [FLIT_WIDTH-1:0] f);
      return f[FLIT_HEAD_BIT];
   endfunction

endpackage

// File: rtl/tg_flit_fifo.sv
// Small circular flit FIFO with occupancy count; read data is the registered head entry.
module tg_flit_fifo #(
   parameter int WIDTH     = 24,
   parameter int LOG_DEPTH = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_i,
   input  logic [WIDTH-1:0]     wdata_i,
   input  logic                 rd_i,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [LOG_DEPTH:0]   count_o
);

   localparam int DEPTH = 2 ** LOG_DEPTH;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr_q;
   logic [LOG_DEPTH-1:0] rd_ptr_q;
   logic [LOG_DEPTH:0]   count_q;
   logic [LOG_DEPTH:0]   count_d;

   always_comb begin
      count_d = count_q;
      if (wr_i && !rd_i) begin
         count_d = count_q + 1'b1;
      end else if (rd_i && !wr_i) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage is cleared on reset so the head output reads zero while empty after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (rd_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == (LOG_DEPTH + 1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/tg_obuf.sv
// Output buffer between the traffic generator and the router injection port,
// with credit-based flow control and a head-flit counter.
module tg_obuf
   import tg_obuf_pkg::*;
#(
   parameter int LOG_DEPTH    = 2,
   parameter int CREDIT_WIDTH = 3,
   parameter int NUM_CREDITS  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [FLIT_WIDTH-1:0] flit_in,
   input  logic                  flit_in_valid,
   output logic                  obuf_full,
   output logic [FLIT_WIDTH-1:0] flit_out,
   output logic                  flit_out_valid,
   input  logic                  credit_in,
   output logic [LOG_DEPTH:0]    occupancy,
   output logic [15:0]           pkts_sent,
   output logic                  credit_err
);

   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(NUM_CREDITS);

   logic                    wr;
   logic                    send;
   logic                    empty;
   logic                    credit_ok;
   logic [CREDIT_WIDTH-1:0] credits_q;
   logic [CREDIT_WIDTH-1:0] credits_d;
   logic [15:0]             pkts_q;
   logic [15:0]             pkts_d;
   logic                    err_q;
   logic                    err_d;

   tg_flit_fifo #(
      .WIDTH     (FLIT_WIDTH),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_i    (wr),
      .wdata_i (flit_in),
      .rd_i    (send),
      .rdata_o (flit_out),
      .full_o  (obuf_full),
      .empty_o (empty),
      .count_o (occupancy)
   );

   // The generator only commits a flit when enable is high, so writes need it too.
   assign wr        = flit_in_valid & enable & ~obuf_full;
   assign send      = ~empty & (credits_q != '0) & enable;
   assign credit_ok = credit_in & (credits_q != CREDIT_MAX);

   // A credit arriving with the counter already full is spurious: ignored and flagged.
   always_comb begin
      credits_d = credits_q;
      case ({send, credit_ok})
         2'b10:   credits_d = credits_q - 1'b1;
         2'b01:   credits_d = credits_q + 1'b1;
         default: credits_d = credits_q;
      endcase
      err_d  = err_q | (credit_in & (credits_q == CREDIT_MAX));
      pkts_d = pkts_q + {15'd0, send & is_head(flit_out)};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         credits_q <= CREDIT_MAX;
         pkts_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         credits_q <= credits_d;
         pkts_q    <= pkts_d;
         err_q     <= err_d;
      end
   end

   assign flit_out_valid = send;
   assign pkts_sent      = pkts_q;
   assign credit_err     = err_q;

endmodule

// File: tb/tb_tg_obuf.sv
// Self-checking bench for tg_obuf: a vector table for single-cycle behaviour plus
// directed sequences for full/drop, streaming with delayed credits, and mid-run reset.
module tb_tg_obuf;
   import tg_obuf_pkg::*;

   localparam int FW = FLIT_WIDTH;

   logic          clock;
   logic          reset;
   logic          enable;
   logic [FW-1:0] flit_in;
   logic          flit_in_valid;
   logic          obuf_full;
   logic [FW-1:0] flit_out;
   logic          flit_out_valid;
   logic          credit_in;
   logic [2:0]    occupancy;
   logic [15:0]   pkts_sent;
   logic          credit_err;

   int testsRun;
   int testsFailed;

   typedef struct {
      int en;
      int v;
      int fin;
      int cr;
      int eValid;
      int eOut;
      int eOcc;
      int eFull;
      int eCred;
      int eErr;
      int ePkts;
   } vec_t;

   vec_t vecs[$];

   tg_obuf #(
      .LOG_DEPTH    (2),
      .CREDIT_WIDTH (3),
      .NUM_CREDITS  (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .flit_in        (flit_in),
      .flit_in_valid  (flit_in_valid),
      .obuf_full      (obuf_full),
      .flit_out       (flit_out),
      .flit_out_valid (flit_out_valid),
      .credit_in      (credit_in),
      .occupancy      (occupancy),
      .pkts_sent      (pkts_sent),
      .credit_err     (credit_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int en, input int v, input int fin, input int cr);
      enable        = en[0];
      flit_in_valid = v[0];
      flit_in       = fin[FW-1:0];
      credit_in     = cr[0];
   endtask

   // One clock with the given inputs, then return to idle at edge+1.
   task automatic cycle(input int en, input int v, input int fin, input int cr);
      applyStimulus(en, v, fin, cr);
      @(posedge clock);
      #1;
      applyStimulus(1, 0, 0, 0);
   endtask

   task automatic resetDut();
      applyStimulus(1, 0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic addVec(input int en, v, fin, cr, eValid, eOut, eOcc, eFull, eCred, eErr, ePkts);
      vec_t r;
      r.en = en; r.v = v; r.fin = fin; r.cr = cr;
      r.eValid = eValid; r.eOut = eOut; r.eOcc = eOcc; r.eFull = eFull;
      r.eCred = eCred; r.eErr = eErr; r.ePkts = ePkts;
      vecs.push_back(r);
   endtask

   function automatic logic [FW-1:0] mkFlit(input int k);
      flit_t f;
      int    p;
      p         = k / 3;
      f         = '0;
      f.head    = (k % 3 == 0);
      f.tail    = (k % 3 == 2);
      f.measure = 1'b1;
      f.ts      = k[7:0];
      f.dest    = p[3:0];
      f.src     = 4'hA;
      return f;
   endfunction

   initial begin
      int            nextIdx;
      int            expIdx;
      int            cycles;
      logic [1:0]    crPipe;
      logic          sentNow;
      vec_t          r;

      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      applyStimulus(1, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_valid", 32'(flit_out_valid), 0);
      checkOutput("rst_flit", 32'(flit_out), 0);
      checkOutput("rst_occ", 32'(occupancy), 0);
      checkOutput("rst_full", 32'(obuf_full), 0);
      checkOutput("rst_cred", 32'(dut.credits_q), 4);
      checkOutput("rst_pkts", 32'(pkts_sent), 0);
      checkOutput("rst_err", 32'(credit_err), 0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Inputs held during a cycle; outputs expected in that same cycle (before its edge).
      //      en v  fin        cr  valid out        occ full cred err pkts
      addVec(1, 1, 'h8000A5, 0,  0,    0,         0,  0,   4,   0,  0);
      addVec(1, 0, 0,        0,  1,    'h8000A5,  1,  0,   4,   0,  0);
      addVec(1, 0, 0,        0,  0,    0,         0,  0,   3,   0,  1);
      addVec(0, 1, 'h000011, 0,  0,    0,         0,  0,   3,   0,  1);
      addVec(0, 1, 'h000011, 0,  0,    0,         0,  0,   3,   0,  1);
      addVec(0, 1, 'h000011, 0,  0,    0,         0,  0,   3,   0,  1);
      addVec(1, 1, 'h000011, 0,  0,    0,         0,  0,   3,   0,  1);
      addVec(1, 0, 0,        0,  1,    'h000011,  1,  0,   3,   0,  1);
      addVec(1, 1, 'h800022, 0,  0,    0,         0,  0,   2,   0,  1);
      addVec(1, 0, 0,        1,  1,    'h800022,  1,  0,   2,   0,  1);
      addVec(1, 0, 0,        1,  0,    0,         0,  0,   2,   0,  2);
      addVec(1, 0, 0,        1,  0,    0,         0,  0,   3,   0,  2);
      addVec(1, 0, 0,        1,  0,    0,         0,  0,   4,   0,  2);
      addVec(1, 0, 0,        0,  0,    0,         0,  0,   4,   1,  2);
      addVec(1, 0, 0,        0,  0,    0,         0,  0,   4,   1,  2);

      for (int i = 0; i < vecs.size(); i++) begin
         r = vecs[i];
         applyStimulus(r.en, r.v, r.fin, r.cr);
         #1;
         checkOutput($sformatf("row%0d_valid", i), 32'(flit_out_valid), r.eValid);
         checkOutput($sformatf("row%0d_flit", i), 32'(flit_out), r.eOut);
         checkOutput($sformatf("row%0d_occ", i), 32'(occupancy), r.eOcc);
         checkOutput($sformatf("row%0d_full", i), 32'(obuf_full), r.eFull);
         checkOutput($sformatf("row%0d_cred", i), 32'(dut.credits_q), r.eCred);
         checkOutput($sformatf("row%0d_err", i), 32'(credit_err), r.eErr);
         checkOutput($sformatf("row%0d_pkts", i), 32'(pkts_sent), r.ePkts);
         @(posedge clock);
         #1;
      end
      applyStimulus(1, 0, 0, 0);

      // Full buffer with no credits: overflow is dropped, one credit frees one slot.
      resetDut();
      for (int i = 0; i < 4; i++) cycle(1, 1, 'h200 + i, 0);
      cycle(1, 0, 0, 0);
      checkOutput("t2_cred_zero", 32'(dut.credits_q), 0);
      checkOutput("t2_drained", 32'(occupancy), 0);
      for (int i = 0; i < 4; i++) cycle(1, 1, 'h100 + i, 0);
      checkOutput("t2_full", 32'(obuf_full), 1);
      checkOutput("t2_occ4", 32'(occupancy), 4);
      checkOutput("t2_no_send", 32'(flit_out_valid), 0);
      cycle(1, 1, 'h1FF, 0);
      checkOutput("t2_drop_occ", 32'(occupancy), 4);
      cycle(1, 0, 0, 1);
      checkOutput("t2_cred_valid", 32'(flit_out_valid), 1);
      checkOutput("t2_still_full", 32'(obuf_full), 1);
      checkOutput("t2_head", 32'(flit_out), 'h100);
      cycle(1, 1, 'h1EE, 0);
      checkOutput("t2_after_send_occ", 32'(occupancy), 3);
      checkOutput("t2_after_send_full", 32'(obuf_full), 0);
      checkOutput("t2_after_send_valid", 32'(flit_out_valid), 0);
      for (int i = 1; i < 4; i++) begin
         cycle(1, 0, 0, 1);
         checkOutput($sformatf("t2_drain%0d_valid", i), 32'(flit_out_valid), 1);
         checkOutput($sformatf("t2_drain%0d_flit", i), 32'(flit_out), 'h100 + i);
         cycle(1, 0, 0, 0);
      end
      checkOutput("t2_final_occ", 32'(occupancy), 0);

      // Ten 3-flit packets, each credit returned two cycles after its send.
      resetDut();
      nextIdx = 0;
      expIdx  = 0;
      cycles  = 0;
      crPipe  = 2'b00;
      while (expIdx < 30 && cycles < 400) begin
         enable        = 1'b1;
         flit_in_valid = (nextIdx < 30) && !obuf_full;
         flit_in       = mkFlit(nextIdx);
         credit_in     = crPipe[1];
         #1;
         sentNow = flit_out_valid;
         if (flit_out_valid) begin
            checkOutput($sformatf("t5_flit%0d", expIdx), 32'(flit_out), 32'(mkFlit(expIdx)));
            expIdx++;
         end
         if (flit_in_valid) nextIdx++;
         @(posedge clock);
         crPipe = {crPipe[0], sentNow};
         #1;
         cycles++;
      end
      applyStimulus(1, 0, 0, 0);
      checkOutput("t5_all_flits", 32'(expIdx), 30);
      checkOutput("t5_pkts", 32'(pkts_sent), 10);

      // Asynchronous reset with flits buffered and one credit outstanding.
      resetDut();
      for (int i = 0; i < 4; i++) cycle(1, 1, 'h300 + i, 0);
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 'h310 + i, 0);
      cycle(1, 0, 0, 1);
      checkOutput("t6_pre_cred", 32'(dut.credits_q), 1);
      checkOutput("t6_pre_occ", 32'(occupancy), 3);
      checkOutput("t6_pre_valid", 32'(flit_out_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_valid", 32'(flit_out_valid), 0);
      checkOutput("t6_occ", 32'(occupancy), 0);
      checkOutput("t6_cred", 32'(dut.credits_q), 4);
      checkOutput("t6_full", 32'(obuf_full), 0);
      checkOutput("t6_flit", 32'(flit_out), 0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
